ppi_tx_unit: RTL

Transmit-side PPI bridge that accepts parallel bytes from the protocol side over a valid/ready handshake and writes them into the write port of the handshake-synchronised FIFO. It is the write-end counterpart of the PPI receive unit. At end of packet it appends a trailer of zero bytes, whose length matches the receiver's zero-run pause detection. It runs entirely in the write-clock domain of the FIFO.

---
 rtl/ppi_tx_unit_pkg.sv | 21 ++
 rtl/ppi_tx_hold.sv | 45 ++++
 rtl/ppi_tx_unit.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/ppi_tx_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ppi_tx_unit_pkg
// Description : Shared PPI definitions: transmit FSM states, default byte
//               width and the trailer length. The receiver's zero-run pause
//               limit is TRAIL_LEN-1 (a count of 23).
// Revision    : 1.0 - initial release
// ============================================================================
package ppi_tx_unit_pkg;

    localparam int unsigned c_DATA_WIDTH = 8;
    localparam int unsigned c_TRAIL_LEN  = 24;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_TRAIL = 2'd2
    } ppi_tx_state_e;

endpackage
`default_nettype wire

// File: rtl/ppi_tx_hold.sv
`default_nettype none
// ============================================================================
// Module      : ppi_tx_hold
// Description : One-entry holding register for the PPI transmit unit.
//               A load wins over a drain, so a byte can be written out and
//               replaced by the next one in the same cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_tx_hold
    import ppi_tx_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_load,
    input  logic                  i_drain,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_last,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_last
);

    logic [DATA_WIDTH-1:0] r_hold_data;
    logic                  r_hold_last;

    // Capture an accepted byte; clear the entry once it has been written out
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
        end else if (i_load) begin
            r_hold_data <= i_data;
            r_hold_last <= i_last;
        end else if (i_drain) begin
            r_hold_data <= '0;
            r_hold_last <= 1'b0;
        end
    end

    assign o_data = r_hold_data;
    assign o_last = r_hold_last;

endmodule
`default_nettype wire

// File: rtl/ppi_tx_unit.sv
`default_nettype none
// ============================================================================
// Module      : ppi_tx_unit
// Description : PPI transmit bridge. Takes bytes over a valid/ready handshake
//               and writes them into the write port of the synchronising FIFO.
//               With PPI_TX_TRAILER_EN defined, each packet is followed by
//               TRAIL_LEN zero bytes; without it TxLast_hs is ignored and
//               packets flow back to back.
// Revision    : 1.0 - initial release
// ============================================================================
module ppi_tx_unit
    import ppi_tx_unit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = c_DATA_WIDTH,
    parameter int unsigned TRAIL_LEN  = c_TRAIL_LEN,
    parameter int unsigned CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] TxData_hs,
    input  logic                  TxValid_hs,
    input  logic                  TxLast_hs,
    output logic                  TxReady_hs,
    input  logic                  w_full,
    output logic [DATA_WIDTH-1:0] w_Data,
    output logic                  winc,
    output logic                  tx_busy
);

    // The trailer counter must be able to reach TRAIL_LEN-1
    if (2**CNT_WIDTH < TRAIL_LEN) begin : g_cnt_width_check
        $error("CNT_WIDTH too narrow for TRAIL_LEN");
    end

    ppi_tx_state_e         r_state;
    ppi_tx_state_e         w_state_nxt;
    logic [DATA_WIDTH-1:0] w_hold_data;
    logic                  w_hold_last;
    logic                  w_last_in;
    logic                  w_winc;
    logic                  w_ready;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic                  w_accept;
    logic                  w_drain;

`ifdef PPI_TX_TRAILER_EN
    logic [CNT_WIDTH-1:0]  r_trail_cnt;
    logic                  w_trail_done;

    assign w_last_in    = TxLast_hs;
    assign w_trail_done = w_winc && (r_trail_cnt == CNT_WIDTH'(TRAIL_LEN - 1));
`else
    // Packet boundaries carry no meaning without a trailer
    assign w_last_in    = TxLast_hs & 1'b0;
`endif

    // Ready is held low for as long as reset is asserted
    assign TxReady_hs = w_ready & rst;
    assign w_accept   = TxValid_hs & TxReady_hs;
    assign w_drain    = (r_state == ST_LOAD) & w_winc;
    assign winc       = w_winc;
    assign w_Data     = w_wdata;
    assign tx_busy    = (r_state != ST_IDLE);

    ppi_tx_hold #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_accept),
        .i_drain (w_drain),
        .i_data  (TxData_hs),
        .i_last  (w_last_in),
        .o_data  (w_hold_data),
        .o_last  (w_hold_last)
    );

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (w_winc) begin
`ifdef PPI_TX_TRAILER_EN
                    if (w_hold_last) begin
                        w_state_nxt = ST_TRAIL;
                    end else
`endif
                    if (w_accept) begin
                        w_state_nxt = ST_LOAD;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
`ifdef PPI_TX_TRAILER_EN
            ST_TRAIL: begin
                if (w_trail_done) begin
                    w_state_nxt = ST_IDLE;
                end
            end
`endif
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output logic: FIFO write strobe, write data and handshake ready
    always_comb begin
        w_winc  = 1'b0;
        w_ready = 1'b0;
        w_wdata = '0;
        case (r_state)
            ST_IDLE: begin
                w_ready = 1'b1;
            end
            ST_LOAD: begin
                w_winc  = ~w_full;
                w_wdata = w_hold_data;
                // The last byte of a packet makes way for the trailer, not a new byte
                w_ready = ~w_full & ~w_hold_last;
            end
`ifdef PPI_TX_TRAILER_EN
            ST_TRAIL: begin
                w_winc = ~w_full;
            end
`endif
            default: begin
                w_winc  = 1'b0;
            end
        endcase
    end

`ifdef PPI_TX_TRAILER_EN
    // Count trailer zeros written; held at zero outside the trailer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_trail_cnt <= '0;
        end else if (r_state != ST_TRAIL) begin
            r_trail_cnt <= '0;
        end else if (w_trail_done) begin
            r_trail_cnt <= '0;
        end else if (w_winc) begin
            r_trail_cnt <= r_trail_cnt + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
